// File: rtl/byte_bus_responder_pkg.sv
// Shared definitions for the byte-serial memory bus responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bus_defs;

    // Byte lane width on the memory bus and in the console FIFO.
    localparam int RamWord = 8;
    typedef logic [RamWord-1:0] byte_t;

    // addr_in[17:16] value that selects the memory-mapped I/O region.
    localparam logic [1:0] IO_SEL = 2'b11;

    // I/O register offsets (addr_in[3:0]).
    localparam logic [3:0] IO_CONSOLE = 4'h0;
    localparam logic [3:0] IO_STATUS  = 4'h4;
    localparam logic [3:0] IO_DROPS   = 4'h8;

endpackage

// File: rtl/byte_bus_responder_if.sv
// Bus bundle between mem_ctrl/console sink (master) and the responder (slave).
// Latency: n/a (wiring only).
// Backpressure: only the console port has a handshake (tx_valid/tx_ready).
interface byte_bus_responder_if;
    import bus_defs::*;

    logic [31:0] addr_in;
    logic        wr_in;
    byte_t       data_in;
    byte_t       data_out;
    byte_t       tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr_in, wr_in, data_in, tx_ready,
        input  data_out, tx_data, tx_valid
    );

    modport slave (
        input  addr_in, wr_in, data_in, tx_ready,
        output data_out, tx_data, tx_valid
    );

endinterface

// File: rtl/byte_bus_responder_io_fifo.sv
// Console output FIFO: circular buffer with registered pointers and count.
// Latency: push visible on head/valid after the pushing edge; pop advances head after its edge.
// Backpressure: a push into a full FIFO with no same-cycle pop is dropped and flagged.
// Ports: clk/rst/en (global enable), push/push_data, pop_ready (sink ready),
//        head/valid (sink side), count/full/empty status, dropped pulse.
module io_fifo
    import bus_defs::*;
#(
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    push,
    input  byte_t                   push_data,
    input  logic                    pop_ready,
    output byte_t                   head,
    output logic                    valid,
    output logic [FIFO_DEPTH_LOG:0] count,
    output logic                    full,
    output logic                    empty,
    output logic                    dropped
);

    localparam int Depth = 1 << FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] DepthCnt = (FIFO_DEPTH_LOG+1)'(Depth);

    byte_t                     storage [Depth];
    logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG:0]   cnt_q;
    logic                      pop;
    logic                      push_ok;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DepthCnt);
    assign count = cnt_q;

    // valid comes from the registered count, so a same-cycle push into an
    // empty FIFO cannot be popped before it has landed in storage.
    assign valid = !empty;
    assign head  = storage[rd_ptr];

    assign pop     = en && !empty && pop_ready;
    // A pop frees the slot this cycle, so a full FIFO still accepts the push.
    assign push_ok = en && push && (!full || pop);
    assign dropped = en && push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                storage[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/byte_bus_responder.sv
// Byte-bus responder: synchronous RAM plus I/O region (console FIFO, halt flag).
// Latency: reads return on data_out one cycle after the address; writes land at the sampling edge.
// Backpressure: none toward mem_ctrl; console drains via tx_valid/tx_ready, overflow bytes dropped.
// Ports: clk, rst (sync active-high), rdy (global enable, freezes all state when low),
//        bus (slave side: addr_in/wr_in/data_in/data_out, tx_data/tx_valid/tx_ready), halt.
// Build option: define BUS_RESP_DROP_CNT_EN to add a saturating dropped-byte counter at I/O 0x8.
module byte_bus_responder
    import bus_defs::*;
#(
    parameter int RAM_ADDR_W     = 17,
    parameter int FIFO_DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    byte_bus_responder_if.slave  bus,
    output logic                 halt
);

    byte_t                   mem [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0]   ram_addr;
    logic                    is_io;
    logic [3:0]              io_off;
    byte_t                   io_rdata;
    logic                    fifo_push;
    logic [FIFO_DEPTH_LOG:0] fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_dropped;
    logic                    unused_ok;

    assign is_io    = (bus.addr_in[17:16] == IO_SEL);
    assign io_off   = bus.addr_in[3:0];
    // Upper address bits are ignored, so the RAM aliases across the map.
    assign ram_addr = bus.addr_in[RAM_ADDR_W-1:0];

    assign fifo_push = is_io && bus.wr_in && (io_off == IO_CONSOLE);

    io_fifo #(
        .FIFO_DEPTH_LOG (FIFO_DEPTH_LOG)
    ) u_io_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .push      (fifo_push),
        .push_data (bus.data_in),
        .pop_ready (bus.tx_ready),
        .head      (bus.tx_data),
        .valid     (bus.tx_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

`ifdef BUS_RESP_DROP_CNT_EN
    byte_t drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (fifo_dropped && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    // I/O read mux; occupancy reflects the count before this edge's push/pop.
    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_STATUS: io_rdata = 8'(fifo_count);
`ifdef BUS_RESP_DROP_CNT_EN
            IO_DROPS:  io_rdata = drop_cnt;
`endif
            default:   io_rdata = '0;
        endcase
    end

    // RAM array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rdy && bus.wr_in && !is_io) begin
            mem[ram_addr] <= bus.data_in;
        end
    end

    // Every cycle is a transaction, so data_out reloads on each enabled edge
    // (writes included); mem_ctrl only samples it after reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out <= '0;
        end else if (rdy) begin
            bus.data_out <= is_io ? io_rdata : mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (rdy && is_io && bus.wr_in && (io_off == IO_STATUS)) begin
            halt <= 1'b1;
        end
    end

    assign unused_ok = ^{bus.addr_in, fifo_full, fifo_empty, fifo_dropped};

endmodule

// File: tb/tb_byte_bus_responder.sv
// Directed self-checking bench for byte_bus_responder.
// Read results are queued when the read is driven and compared one edge later.
// A model queue of console bytes tracks expected FIFO contents and drain order.
module tb_byte_bus_responder;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic halt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];   // pending read results
    logic [7:0] model [$];   // expected console FIFO contents

    byte_bus_responder_if bus_if ();

    byte_bus_responder dut (
        .clk  (clk),
        .rst  (rst),
        .rdy  (rdy),
        .bus  (bus_if),
        .halt (halt)
    );

    always #5 clk = ~clk;

`ifdef BUS_RESP_DROP_CNT_EN
    localparam logic [7:0] ExpDrops = 8'h02;
`else
    localparam logic [7:0] ExpDrops = 8'h00;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [7:0] d);
        bus_if.addr_in = a;
        bus_if.wr_in   = 1'b1;
        bus_if.data_in = d;
        @(posedge clk); #1;
        bus_if.wr_in   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] e, input string tag);
        logic [7:0] want;
        exp_q.push_back(e);
        bus_if.addr_in = a;
        bus_if.wr_in   = 1'b0;
        @(posedge clk); #1;
        want = exp_q.pop_front();
        chk(tag, bus_if.data_out, want);
    endtask

    task automatic idle();
        bus_if.addr_in = 32'h1000;
        bus_if.wr_in   = 1'b0;
        @(posedge clk); #1;
    endtask

    // Console push with tx_ready low: model accepts only while not full.
    task automatic push_byte(input logic [7:0] d);
        wr_cyc(32'h30000, d);
        if (model.size() < 8) model.push_back(d);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 16 && model.size() > 0; k++) begin
            chk("drain_valid", bus_if.tx_valid, 1);
            chk("drain_data", bus_if.tx_data, model[0]);
            bus_if.tx_ready = 1'b1;
            idle();
            void'(model.pop_front());
        end
        bus_if.tx_ready = 1'b0;
        chk("drained_empty", bus_if.tx_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus_if.addr_in  = 32'h0;
        bus_if.wr_in    = 1'b0;
        bus_if.data_in  = 8'h00;
        bus_if.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", bus_if.data_out, 8'h00);
        chk("rst_tx_valid", bus_if.tx_valid, 0);
        chk("rst_tx_data", bus_if.tx_data, 8'h00);
        chk("rst_halt", halt, 0);
        rst = 1'b0;

        // RAM back-to-back writes then reads
        wr_cyc(32'h1000, 8'h11);
        wr_cyc(32'h1001, 8'h22);
        wr_cyc(32'h1002, 8'h33);
        wr_cyc(32'h1003, 8'h44);
        rd(32'h1000, 8'h11, "ram_rd0");
        rd(32'h1001, 8'h22, "ram_rd1");
        rd(32'h1002, 8'h33, "ram_rd2");
        rd(32'h1003, 8'h44, "ram_rd3");
        // alias: bit 17 set but not I/O (bits 17:16 = 10)
        rd(32'h21000, 8'h11, "ram_alias");

        // Single console byte
        push_byte(8'h41);
        rd(32'h30004, 8'h01, "occ_one");
        chk("one_valid", bus_if.tx_valid, 1);
        chk("one_data", bus_if.tx_data, 8'h41);
        bus_if.tx_ready = 1'b1;
        rd(32'h1000, 8'h11, "rd_during_pop");
        void'(model.pop_front());
        bus_if.tx_ready = 1'b0;
        chk("one_popped", bus_if.tx_valid, 0);
        rd(32'h30004, 8'h00, "occ_zero");
        rd(32'h30000, 8'h00, "console_rd");

        // Overflow: 10 pushes into depth 8
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        rd(32'h30004, 8'h08, "occ_full");
        rd(32'h30008, ExpDrops, "drop_cnt");
        drain_all();

        // Full FIFO push+pop in one cycle
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        bus_if.tx_ready = 1'b1;
        wr_cyc(32'h30000, 8'h55);
        void'(model.pop_front());
        model.push_back(8'h55);
        bus_if.tx_ready = 1'b0;
        rd(32'h30004, 8'h08, "occ_full_pushpop");
        rd(32'h30008, ExpDrops, "drop_cnt_hold");
        drain_all();

        // Empty FIFO push+pop: only the push happens
        bus_if.tx_ready = 1'b1;
        wr_cyc(32'h30000, 8'h66);
        model.push_back(8'h66);
        bus_if.tx_ready = 1'b0;
        chk("empty_pp_valid", bus_if.tx_valid, 1);
        chk("empty_pp_data", bus_if.tx_data, 8'h66);
        rd(32'h30004, 8'h01, "occ_empty_pp");
        drain_all();

        // rdy low freezes everything
        push_byte(8'h77);
        wr_cyc(32'h2000, 8'hA5);
        rd(32'h2000, 8'hA5, "ram_2000");
        rdy = 1'b0;
        bus_if.tx_ready = 1'b1;
        bus_if.addr_in  = 32'h2000;
        bus_if.wr_in    = 1'b1;
        bus_if.data_in  = 8'h5A;
        @(posedge clk); #1;
        chk("frozen_data_out", bus_if.data_out, 8'hA5);
        chk("frozen_valid", bus_if.tx_valid, 1);
        chk("frozen_head", bus_if.tx_data, 8'h77);
        rdy = 1'b1;
        bus_if.wr_in    = 1'b0;
        bus_if.tx_ready = 1'b0;
        rd(32'h30004, 8'h01, "frozen_occ");
        rd(32'h2000, 8'hA5, "frozen_ram");
        drain_all();

        // Halt sticky, then reset mid-drain
        push_byte(8'h88);
        wr_cyc(32'h30004, 8'h00);
        chk("halt_set", halt, 1);
        wr_cyc(32'h1004, 8'h99);
        rd(32'h1004, 8'h99, "ram_1004");
        chk("halt_sticky", halt, 1);
        rst = 1'b1;
        bus_if.tx_ready = 1'b1;
        @(posedge clk); #1;
        model.delete();
        chk("rst2_halt", halt, 0);
        chk("rst2_tx_valid", bus_if.tx_valid, 0);
        chk("rst2_tx_data", bus_if.tx_data, 8'h00);
        chk("rst2_data_out", bus_if.data_out, 8'h00);
        rst = 1'b0;
        bus_if.tx_ready = 1'b0;
        rd(32'h30004, 8'h00, "rst2_occ");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
